// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of the shared 4:1 mux select lines. One grant at a time,
// each tenure capped at HOLD_MAX cycles so no requester can starve the rest.
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       preempt
);

  // state | meaning
  // IDLE  | no owner, gnt = 0, sel holds the last owner
  // GRANT | one owner (index in sel), gnt one-hot, cnt counts its held cycles
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(HOLD_MAX - 1);

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;

  logic [1:0] owner;
  logic       drop;
  logic       at_limit;
  logic [3:0] others;
  logic [3:0] next_pool;
  logic [2:0] pick_idle;
  logic [2:0] pick_next;

  // Returns {hit, index} of the first set bit of r, scanning start, start+1, ...
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  always_comb begin
    owner     = sel;
    drop      = ~req[owner];
    at_limit  = (cnt == LIMIT);
    others    = req & ~onehot(owner);
    next_pool = drop ? req : others;
    pick_idle = rr_pick(req, ptr);
    pick_next = rr_pick(next_pool, owner + 2'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= 4'b0000;
      sel     <= 2'b00;
      busy    <= 1'b0;
      preempt <= 1'b0;
      ptr     <= 2'b00;
      cnt     <= '0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_idle[2]) begin
            state <= GRANT;
            gnt   <= onehot(pick_idle[1:0]);
            sel   <= pick_idle[1:0];
            ptr   <= pick_idle[1:0] + 2'd1;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        GRANT: begin
          if (drop) begin
            cnt <= '0;
            if (pick_next[2]) begin
              gnt <= onehot(pick_next[1:0]);
              sel <= pick_next[1:0];
              ptr <= pick_next[1:0] + 2'd1;
            end else begin
              state <= IDLE;
              gnt   <= 4'b0000;
              busy  <= 1'b0;
            end
          end else if (at_limit) begin
            preempt <= 1'b1;
            cnt     <= '0;
            // With nobody else waiting the owner simply starts a fresh tenure.
            if (pick_next[2]) begin
              gnt <= onehot(pick_next[1:0]);
              sel <= pick_next[1:0];
              ptr <= pick_next[1:0] + 2'd1;
            end else begin
              ptr <= owner + 2'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'b0000;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares the team's 4:1 single-bit multiplexer between four requesters. It owns the mux `sel` lines: it grants one requester at a time, drives `sel` with the winner's index, and bounds each tenure to `HOLD_MAX` cycles so that no requester can starve the others. It sits directly in front of the mux, with requester `i` wired to mux data input `i` (`a`=0, `b`=1, `c`=2, `d`=3).

## Interface
- `HOLD_MAX`, default 8: maximum consecutive cycles one grant is held. Legal range 1..255.
- `CNT_W`, default 8: width of the tenure counter. Must satisfy 2^CNT_W > HOLD_MAX.
- `clk`, input, 1: the single clock. All state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, 4: level request per requester. Held high while the requester wants the mux.
- `gnt`, output, 4: registered, one-hot or zero. Current owner.
- `sel`, output, 2: registered binary index of the current or last owner. Drives the mux `sel`.
- `busy`, output, 1: registered. High whenever `gnt != 0`.
- `preempt`, output, 1: registered one-cycle pulse. High when a tenure is ended by the `HOLD_MAX` limit.

## Operation
- State machine:
  - `IDLE`: no owner, `gnt`=0.
  - `GRANT`: one owner, `gnt` one-hot.
- Round-robin pointer `ptr` (2 bits) holds the index where the next search starts. The search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4. The first requester found wins.
- Tenure counter `cnt` (`CNT_W` bits) counts the cycles the current owner has held the grant, starting at 0.
- `IDLE` -> `GRANT` when `req != 0`. The winner is taken from the search, and `cnt` is set to 0.
- `GRANT`, owner `o`, release condition: `req[o]==0` OR `cnt==HOLD_MAX-1`.
  - No release: stay in `GRANT` and increment `cnt`.
  - Release by drop (`req[o]==0`): search from `o+1` among `req`. A hit hands over directly in the same edge and sets `cnt` to 0. No hit returns to `IDLE`.
  - Release by limit (`req[o]==1`, `cnt==HOLD_MAX-1`): `preempt` pulses.
    - If another requester is pending, search from `o+1`, excluding `o`.
    - If only `o` is requesting, re-grant `o` with `cnt`=0.
    - If both conditions hold in the same cycle, drop wins: no `preempt`.
- On every new grant to index `w`: `ptr` becomes `w+1` mod 4, and `sel` becomes `w`.
- `sel` holds its last value in `IDLE`. The mux output stays stable but meaningless while `busy`=0.
- `HOLD_MAX`=1: every granted cycle is a limit release, so the grant rotates each cycle under contention.

## Timing
- Reset (async assert, synchronous effect on deassert): `gnt`=0, `sel`=2'b00, `busy`=0, `preempt`=0, `ptr`=0, `cnt`=0, state=`IDLE`.
- Reset asserted mid-tenure: all outputs go to reset values immediately, without waiting for a clock edge.
- Request-to-grant latency is 1 cycle. If `req` rises before edge N, `gnt`, `sel` and `busy` are valid after edge N.
- Handover takes 0 dead cycles. The new owner's `gnt` is asserted at the same edge where the old owner's `gnt` drops.
- Drop release: when `req[o]` falls before edge N, `gnt[o]` clears at edge N.
- Maximum tenure is exactly `HOLD_MAX` cycles of `gnt` high.
- A requester waits at most 3×`HOLD_MAX` cycles from its first sampled request to its grant.
- `preempt` is high for exactly the cycle following the limit edge, aligned with the new `gnt`.
- `req` changes on non-owner lines never alter the current tenure.
- `gnt` is never multi-hot in any cycle, and `busy` == `|gnt` at all times.

## Test plan
- **Reset:** hold `rst_n`=0 with `req`=4'b1111, then release. Required: `gnt`=0 and `sel`=0 throughout reset. At the first edge after release, `gnt`=4'b0001, `sel`=0, `busy`=1.
- **Single requester with drop:** `req`=4'b0100 for 3 cycles, then 0, with `HOLD_MAX`=8. Required: `gnt`=4'b0100 and `sel`=2 for 3 cycles, then `gnt`=0. `sel` stays 2 and `preempt` never pulses.
- **Full contention:** `req`=4'b1111 held, `HOLD_MAX`=4. Required: grants cycle 0,1,2,3,0 with exactly 4 cycles each. `preempt` pulses at every handover, and `gnt` is always one-hot.
- **Direct handover:** owner 1 drops `req[1]` while `req`=4'b1001. Required: at the next edge `gnt`=4'b1000 (search from 2 finds 3), with no idle cycle and `preempt`=0.
- **Lone hog:** `req`=4'b0010 held, `HOLD_MAX`=3. Required: `gnt` stays 4'b0010 continuously, and `preempt` pulses every 3 cycles. Raising `req[3]` during a tenure moves the grant to 3 at that tenure's limit edge.
- **Async reset mid-tenure:** pulse `rst_n` low between edges while `gnt`=4'b1000. Required: `gnt`=0 and `sel`=0 immediately, and arbitration restarts from `ptr`=0.
